// File: rtl/axilite_if.sv
// AXI4-lite channel bundle between a command master and a memory-style slave.
// Master drives requests and response readies; slave drives the rest.
interface axilite_if #(
  parameter int AW = 32,
  parameter int DW = 64
) ();
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axilite_cmd_master.sv
// Single-outstanding AXI-lite master: turns one command into one bus
// transaction and returns one response, with optional response timeout.
module axilite_cmd_master #(
  parameter int AW    = 32,
  parameter int BWL2  = 3,
  parameter int TOL2  = 8,
  parameter int TO_EN = 1,
  localparam int DW   = 8 << BWL2,
  localparam int SW   = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [SW-1:0] cmd_wstrb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    rsp_resp,
  output logic          rsp_timeout,
  axilite_if.master     axil
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP, DRAIN
  } state_t;

  state_t          state;
  logic            drain;
  logic            is_wr;
  logic [TOL2-1:0] cnt;

  logic aw_ok, w_ok, b_hs, r_hs, to_hit, late_hs;

  // A channel counts as done once its valid has already dropped.
  assign aw_ok   = !axil.awvalid || axil.awready;
  assign w_ok    = !axil.wvalid || axil.wready;
  assign b_hs    = axil.bvalid && axil.bready;
  assign r_hs    = axil.rvalid && axil.rready;
  assign to_hit  = (TO_EN != 0) && (cnt == '1);
  assign late_hs = drain && (is_wr ? b_hs : r_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      drain        <= 1'b0;
      is_wr        <= 1'b0;
      cnt          <= '0;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_resp     <= 2'b00;
      rsp_timeout  <= 1'b0;
      axil.awvalid <= 1'b0;
      axil.wvalid  <= 1'b0;
      axil.arvalid <= 1'b0;
      axil.bready  <= 1'b0;
      axil.rready  <= 1'b0;
      axil.awaddr  <= '0;
      axil.araddr  <= '0;
      axil.wdata   <= '0;
      axil.wstrb   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            is_wr       <= cmd_write;
            axil.awaddr <= cmd_addr;
            axil.araddr <= cmd_addr;
            axil.wdata  <= cmd_wdata;
            axil.wstrb  <= cmd_wstrb;
            if (cmd_write) begin
              axil.awvalid <= 1'b1;
              axil.wvalid  <= 1'b1;
              state        <= WR_ADDR;
            end else begin
              axil.arvalid <= 1'b1;
              state        <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (axil.awready) axil.awvalid <= 1'b0;
          if (axil.wready)  axil.wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            axil.bready <= 1'b1;
            cnt         <= '0;
            state       <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            rsp_valid   <= 1'b1;
            rsp_resp    <= axil.bresp;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            axil.bready <= 1'b0;
            state       <= RSP;
          end else if (to_hit) begin
            rsp_valid   <= 1'b1;
            rsp_resp    <= 2'b10;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            drain       <= 1'b1;
            state       <= RSP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_ADDR: begin
          if (axil.arready) begin
            axil.arvalid <= 1'b0;
            axil.rready  <= 1'b1;
            cnt          <= '0;
            state        <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            rsp_valid   <= 1'b1;
            rsp_resp    <= axil.rresp;
            rsp_rdata   <= axil.rdata;
            rsp_timeout <= 1'b0;
            axil.rready <= 1'b0;
            state       <= RSP;
          end else if (to_hit) begin
            rsp_valid   <= 1'b1;
            rsp_resp    <= 2'b10;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            drain       <= 1'b1;
            state       <= RSP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RSP: begin
          // A late beat after a timeout is swallowed here or in DRAIN.
          if (late_hs) begin
            drain       <= 1'b0;
            axil.bready <= 1'b0;
            axil.rready <= 1'b0;
          end
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (drain && !late_hs) begin
              state <= DRAIN;
            end else begin
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (late_hs) begin
            drain       <= 1'b0;
            axil.bready <= 1'b0;
            axil.rready <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axilite_cmd_master.md
AXILITE_CMD_MASTER -- requirements
Module: axilite_cmd_master

Interface
REQ-001 SHALL have parameter AW, default 32, AXI-lite address width.
REQ-002 SHALL have parameter BWL2, default 3, log2 of data bytes; DW = 8*2**BWL2.
REQ-003 SHALL have parameter TOL2, default 8, log2 of response timeout in cycles.
REQ-004 SHALL have parameter TO_EN, default 1, 1 enables response timeout.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_valid  input  1  command request.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-009 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have port cmd_addr  input  AW  byte address.
REQ-011 SHALL have port cmd_wdata  input  DW  write data.
REQ-012 SHALL have port cmd_wstrb  input  DW/8  write byte strobes.
REQ-013 SHALL have port rsp_valid  output  1  response available.
REQ-014 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-015 SHALL have port rsp_rdata  output  DW  read data (0 for writes and timeouts).
REQ-016 SHALL have port rsp_resp  output  2  captured BRESP/RRESP; 2'b10 on timeout.
REQ-017 SHALL have port rsp_timeout  output  1  response generated by timeout.
REQ-018 SHALL have port axil  axilite_if.master  -  AXI-lite master port feeding axilite_bram_ctlr-class slaves.

Function
REQ-019 SHALL implement states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP, DRAIN.
REQ-020 SHALL drive cmd_ready high only in IDLE, and low while rst_n is low.
REQ-021 SHALL, on cmd handshake in cycle N, register addr/data/strb and assert awvalid+wvalid (write) or arvalid (read) from cycle N+1.
REQ-022 SHALL in WR_ADDR track AW and W handshakes independently; each valid drops the cycle after its own handshake; enter WR_RESP once both are done (same-cycle completion allowed).
REQ-023 SHALL never deassert awvalid, wvalid or arvalid before the corresponding handshake; no timeout applies to address/data phases.
REQ-024 SHALL in RD_ADDR hold arvalid until arready, then enter RD_DATA.
REQ-025 SHALL assert bready only in WR_RESP (and drain, REQ-030), rready only in RD_DATA (and drain).
REQ-026 SHALL on bvalid&bready capture bresp, rdata=0, timeout=0, go RSP; on rvalid&rready capture rdata/rresp, go RSP.
REQ-027 SHALL hold rsp_valid and all rsp_* stable in RSP until rsp_ready; on handshake go IDLE (cmd_ready high next cycle).
REQ-028 SHALL, with TO_EN=1, clear a TOL2-bit counter on entry to WR_RESP/RD_DATA, increment each cycle without response, and at count 2**TOL2-1 go RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, drain flag set.
REQ-029 SHALL give a response handshake priority over timeout in the same cycle (normal response, no drain).
REQ-030 SHALL, while drain flag set, keep bready/rready (per pending type) high in RSP and DRAIN, discard the late response and clear the flag; RSP handshake goes DRAIN if flag still set, DRAIN goes IDLE on late handshake.
REQ-031 SHALL, with TO_EN=0, wait indefinitely in WR_RESP/RD_DATA.
REQ-032 SHALL drive awaddr/araddr with the full registered cmd_addr, unmodified.

Reset
REQ-033 SHALL on rst_n low immediately force state IDLE, drain flag 0, counter 0, and awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_timeout, cmd_ready to 0, rsp_rdata/rsp_resp to 0.
REQ-034 SHALL abandon any in-flight transaction on reset; first cmd accepted no earlier than the first rising edge after rst_n rises.

Verification
REQ-035 Write addr 0x40, wdata 0x1122334455667788, wstrb 0xFF, slave always ready, bresp 0 -> aw/w valid cycle N+1, bready N+2, rsp_valid N+3 with resp 0, timeout 0.
REQ-036 Write with wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held; single B accepted; one response.
REQ-037 Read addr 0x80, slave rvalid 2 cycles after arready, rdata 0xDEADBEEF00C0FFEE, rresp 2'b10 -> rsp_rdata/rsp_resp match, held under rsp_ready low for 5 cycles.
REQ-038 TOL2=4, read with rvalid at cycle 20 after AR -> rsp_timeout=1, resp 2'b10, rdata 0 at count 15; late R discarded; next cmd gets its own data.
REQ-039 rvalid arriving exactly in the timeout-limit cycle -> normal response, rsp_timeout 0, no drain.
REQ-040 rst_n low during WR_RESP -> all valids/readies 0 immediately; after release write completes normally.
